// File: rtl/ram_burst_pkg.sv
// Shared types and default widths for the RAM burst master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro RAM_BURST_NOWRAP_EN is consumed by the interface and top.
package ram_burst_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Bundles command, write stream, read stream, status and RAM pins of the burst master.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready / wr_ready / rd_ready carry all flow control.
// master = burst controller side, slave = host + RAM side.
// Macro RAM_BURST_NOWRAP_EN adds the err pulse output.
interface ram_burst_master_if
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
`ifdef RAM_BURST_NOWRAP_EN
    logic              err;
`endif

    modport master (
`ifdef RAM_BURST_NOWRAP_EN
        output err,
`endif
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, ram_dout,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, done, ram_we, ram_addr, ram_din
    );

    modport slave (
`ifdef RAM_BURST_NOWRAP_EN
        input  err,
`endif
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, ram_dout,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/ram_rd_skid.sv
// 2-entry skid buffer on the RAM read return path, with fall-through when empty.
// Latency: 0 cycles when empty (din shows straight on rd_data), else from the head entry.
// Backpressure: rd_ready low holds rd_data; caller must not push into a full buffer.
// Ports: clk, rst, push/din (fill side), rd_valid/rd_ready/rd_data (drain side), count (stored entries).
module ram_rd_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic              wptr;
    logic              rptr;
    logic [1:0]        cnt;
    logic              empty;
    logic              store;
    logic              take;

    assign empty    = (cnt == 2'd0);
    assign rd_valid = !empty || push;
    assign rd_data  = (empty && push) ? din : mem[rptr];
    assign count    = cnt;

    // An incoming beat consumed in the same cycle it arrives never gets stored.
    assign store = push && !(empty && rd_ready);
    assign take  = rd_ready && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (store) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (take) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + {1'b0, store} - {1'b0, take};
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst controller in front of a single-port RAM with 1-cycle registered read.
// Latency: write beats hit the RAM on their handshake edge; first read beat 2 cycles after command accept.
// Backpressure: cmd_ready only in IDLE; wr_ready whole WRITE burst; reads throttled to 2 outstanding.
// Ports: clk, rst (async, active-high), bus (ram_burst_master_if.master).
// Macro RAM_BURST_NOWRAP_EN: bursts crossing the top address are rejected with an err pulse.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    ram_burst_master_if.master bus
);
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_hold_q;
    logic              inflight_q;
    logic              done_q;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic [1:0]        skid_cnt;
    logic              pop;
    logic              issue;
    logic              wr_beat;
    logic              last_beat;
    logic [2:0]        occ;
`ifdef RAM_BURST_NOWRAP_EN
    logic              err_q;
    logic              crosses;

    assign crosses = ({1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len}) > {1'b0, {ADDR_W{1'b1}}};
    assign bus.err = err_q;
`endif

    ram_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .din      (bus.ram_dout),
        .rd_valid (skid_vld),
        .rd_ready (bus.rd_ready),
        .rd_data  (skid_dat),
        .count    (skid_cnt)
    );

    assign pop       = skid_vld && bus.rd_ready;
    assign wr_beat   = (state == WRITE) && bus.wr_valid;
    assign last_beat = (cnt_q == len_q);
    // Occupancy the skid will hold after this edge; an issue now lands next cycle,
    // so keeping this below 2 means the skid can never overflow.
    assign occ       = {1'b0, skid_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue     = (state == READ) && (occ < 3'd2);

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.wr_ready  = (state == WRITE);
    assign bus.ram_we    = wr_beat;
    assign bus.ram_addr  = (state == WRITE || state == READ) ? addr_q : addr_hold_q;
    assign bus.ram_din   = (state == WRITE) ? bus.wr_data : '0;
    assign bus.rd_valid  = skid_vld;
    assign bus.rd_data   = skid_dat;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_hold_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef RAM_BURST_NOWRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
`ifdef RAM_BURST_NOWRAP_EN
            err_q      <= 1'b0;
`endif
            // Remember the last address driven so ram_addr stays put once idle.
            if (state == WRITE || state == READ) begin
                addr_hold_q <= addr_q;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q <= bus.cmd_addr;
                        len_q  <= bus.cmd_len;
                        cnt_q  <= '0;
`ifdef RAM_BURST_NOWRAP_EN
                        if (crosses) begin
                            err_q <= 1'b1;
                        end else begin
                            state <= bus.cmd_write ? WRITE : READ;
                        end
`else
                        state <= bus.cmd_write ? WRITE : READ;
`endif
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight_q && skid_cnt == 2'd0) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
Initiator-side controller for the single-port synchronous RAM (clk, we, addr, din, dout; registered read, 1-cycle latency).
- Accepts burst commands on a valid/ready interface.
- Sequences RAM writes from a write-data stream, and RAM reads into a read-data stream with full backpressure.
- Sits between host logic and the RAM, replacing hand-driven we/addr/din sequencing.

Parameters:
ADDR_W, 4, RAM address width; also burst length field width
DATA_W, 8, RAM data width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  ADDR_W  beats minus one (0 = 1 beat, max 2^ADDR_W beats)
wr_valid  input  1  write beat offered
wr_ready  output  1  write beat accepted
wr_data  input  DATA_W  write beat data
rd_valid  output  1  read beat available
rd_ready  input  1  read beat consumed
rd_data  output  DATA_W  read beat data
busy  output  1  burst in progress (state != IDLE)
done  output  1  one-cycle pulse on burst completion
ram_we  output  1  to RAM we
ram_addr  output  ADDR_W  to RAM addr
ram_din  output  DATA_W  to RAM din
ram_dout  input  DATA_W  from RAM dout

Behaviour:
- Reset (async, any state): state IDLE; beat counter 0; in-flight flag 0; skid empty; cmd_ready=0 during reset, 1 from first IDLE cycle; busy, done, rd_valid, wr_ready, ram_we = 0; ram_addr, ram_din, rd_data = 0.
- Reset mid-burst aborts the burst: no done, skid contents discarded.
- FSM IDLE -> WRITE | READ -> (READ only) DRAIN -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr, len and direction; enter WRITE or READ next cycle. Commands are accepted only in IDLE.
- WRITE:
  - wr_ready=1.
  - Driven combinationally: ram_we = wr_valid; ram_addr = current address; ram_din = wr_data. The RAM samples the beat on the same edge as the handshake.
  - Each accepted beat increments address (mod 2^ADDR_W) and count.
  - Beat with count==len returns to IDLE.
- READ:
  - Issue one address per cycle while (skid occupancy + in-flight) < 2; ram_we=0; ram_addr = current address.
  - The issue sets the in-flight flag; next cycle ram_dout is pushed into the skid.
  - After the issue with count==len, go to DRAIN.
- DRAIN: wait until in-flight=0 and skid empty, then IDLE.
- Read stream:
  - rd_valid/rd_data come from the skid head.
  - rd_data is held stable while rd_valid & !rd_ready.
  - Sustained throughput is 1 beat/cycle with rd_ready held high.
  - First rd_valid appears 2 cycles after command acceptance.
- done: registered; high for exactly the first IDLE cycle after a burst. A new command may be accepted in that cycle.
- ram_we is 0 outside WRITE. ram_addr holds its last value when idle.
- Address wrap: with the optional feature off, a burst crossing 2^ADDR_W-1 wraps to 0.

Optional Feature:
RAM_BURST_NOWRAP_EN
- Defined: in IDLE, a command with cmd_addr + cmd_len > 2^ADDR_W-1 is accepted but not executed. The FSM stays in IDLE, and output err (1 bit, added only under the macro) pulses one cycle, with no done and no RAM access.
- Undefined: no err port; bursts wrap modulo 2^ADDR_W.

Decomposition:
- Package ram_burst_pkg: state enum (IDLE, WRITE, READ, DRAIN) and default widths ADDR_W_DEF=4, DATA_W_DEF=8.
- Sub-module ram_rd_skid: 2-entry valid/ready skid buffer (push, din, pop side rd_valid/rd_ready/rd_data, count output) used on the read return path.

Test Plan:
- Write len=1 at addr 4 with data A5, 3C -> RAM[4]=A5, RAM[5]=3C; done pulses once; busy high 2 cycles.
- Read len=1 at addr 4, rd_ready=1 -> rd_data A5 then 3C on consecutive cycles; first rd_valid 2 cycles after cmd accept.
- Read len=3 at addr 4 with rd_ready toggling 1,0,0,1,... -> no beat lost or duplicated; rd_data stable while stalled; at most 2 reads outstanding.
- Write len=2 at addr E (data 11, 22, 33), then read back -> RAM[E]=11, RAM[F]=22, RAM[0]=33. With RAM_BURST_NOWRAP_EN -> err pulse, RAM unchanged, no done.
- Read unwritten addr 2, len 0 -> rd_data 00 (RAM model zero-initialised).
- Assert rst during the 2nd beat of a 4-beat read -> all outputs 0 immediately; no done; next command after reset executes normally.
